d16_fetch: RTL and testbench
============================

D16_FETCH -- requirements
Module: d16_fetch

Interface
REQ-001 SHALL have ports: sys_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: sys_rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: en  in  1  hazard-unit enable; 0 = DI stage stalled, LI/DI outputs must hold.
REQ-004 SHALL have: jmp  in  1  taken branch/jump this cycle; jmp_addr  in  16  target PC.
REQ-005 SHALL have: imem_adr  out  16  fetch address; imem_stb  out  1  request valid.
REQ-006 SHALL have: imem_ack  in  1  response valid this cycle, qualified by imem_stb; imem_dat  in  56  {op[55:48], a[47:32], b[31:16], c[15:0]}.
REQ-007 SHALL have: li_di_op  out  8, li_di_a/li_di_b/li_di_c  out  16 each, li_pc  out  16; the registered LI/DI instruction fields and their address.

Function
REQ-008 SHALL keep pc (16 bit) as the next address to fetch; pc increments by 1 modulo 2^16 (0xFFFF -> 0x0000) on each accepted ack.
REQ-009 SHALL implement FSM states IDLE, REQ, HOLD; IDLE -> REQ unconditionally one cycle after reset release.
REQ-010 In REQ, SHALL drive imem_stb=1, imem_adr=pc, stable until ack or jmp.
REQ-011 On ack with en=1 and jmp=0: SHALL load li_di_* from imem_dat and li_pc<=pc on that edge (1-cycle ack-to-output latency), pc<=pc+1, remain in REQ (back-to-back fetch, no dead cycle).
REQ-012 On ack with en=0 and jmp=0: SHALL capture imem_dat and pc in a hold register, pc<=pc+1, drop imem_stb, go HOLD; li_di_* unchanged.
REQ-013 In HOLD with en=1: SHALL move hold register to li_di_*/li_pc, go REQ; with en=0 stay in HOLD, all outputs unchanged.
REQ-014 In REQ with no ack: en=1 SHALL load li_di_op<=0 (NOP bubble), a/b/c/li_pc unchanged; en=0 SHALL hold all outputs.
REQ-015 jmp=1 SHALL take priority over ack, en and state: pc<=jmp_addr, li_di_op<=0, hold/buffer contents discarded, any ack this cycle discarded, next state REQ with imem_adr=jmp_addr.
REQ-016 jmp and en=0 in the same cycle SHALL still flush (jmp wins).
REQ-017 Memory SHALL treat an imem_adr change while imem_stb=1 as a new request; block never issues more than one outstanding request.

Reset
REQ-018 On sys_rst=1: pc=0, state IDLE, imem_stb=0, imem_adr=0, li_di_op=0, li_di_a=li_di_b=li_di_c=0, li_pc=0, hold/buffer empty.
REQ-019 sys_rst asserted mid-request SHALL abandon it; acks during reset ignored.

Configuration
REQ-020 Macro D16_FETCH_PREFETCH_EN SHALL select the buffering scheme.
REQ-021 Defined: HOLD replaced by 2-entry FIFO (count 0..2); imem_stb=1 whenever count<2 or an entry pops this cycle; fetch continues during en=0 until full; en=1 pops head into li_di_*; when empty an ack with en=1 bypasses straight to li_di_* (same latency as REQ-011); jmp flushes FIFO to count 0.
REQ-022 Undefined: single hold register and FSM of REQ-009..REQ-014; no fetch while in HOLD.

Verification
REQ-023 Reset release, ack each cycle with dat=pc-derived pattern, en=1 -> imem_adr 0,1,2,...; li_di_op/li_pc follow one cycle after each ack, no gaps.
REQ-024 en=0 for 3 cycles while ack at pc=5 -> li_di_* holds instr 4; stb low in HOLD (macro off) / stb stays high until count=2 (macro on); after en=1 instrs 5,6 emerge in order.
REQ-025 jmp=1, jmp_addr=0x0100 in same cycle as ack for pc=7 -> instr 7 discarded, li_di_op=0 next cycle, next imem_adr=0x0100.
REQ-026 pc=0xFFFF fetched -> next imem_adr=0x0000, li_pc=0xFFFF on that instruction.
REQ-027 Ack latency 3 cycles, en=1 -> li_di_op=0 during wait cycles, a/b/c unchanged; sys_rst pulse during wait -> all outputs to reset values, next fetch at 0.

Source files
------------

// File: rtl/d16_fetch.sv
// d16_fetch: instruction fetch unit feeding the LI/DI pipeline register.
//
// Keeps the next fetch address (pc), issues single-outstanding requests to
// instruction memory and loads the returned 56-bit word into the LI/DI
// fields.
//
// Taken jumps flush the unit. Hazard stalls (en=0) freeze the LI/DI fields.
//
// Build option:
//   D16_FETCH_PREFETCH_EN  undefined : one hold register; fetching stops while
//                                      a stalled word is parked in HOLD.
//                          defined   : 2-entry prefetch FIFO; fetching keeps
//                                      going during a stall until the FIFO is
//                                      full.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   en                        hazard enable (0 = LI/DI stalled)
//   jmp, jmp_addr             taken branch/jump and its target
//   imem_adr, imem_stb        fetch address / request valid
//   imem_ack, imem_dat        response valid / {op, a, b, c}
//   li_di_op/a/b/c, li_pc     registered instruction fields and their address
module d16_fetch (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic        jmp,
  input  logic [15:0] jmp_addr,
  output logic [15:0] imem_adr,
  output logic        imem_stb,
  input  logic        imem_ack,
  input  logic [55:0] imem_dat,
  output logic [7:0]  li_di_op,
  output logic [15:0] li_di_a,
  output logic [15:0] li_di_b,
  output logic [15:0] li_di_c,
  output logic [15:0] li_pc
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic        ack_ok;

  assign imem_adr = pc;
  assign ack_ok   = imem_ack && imem_stb;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

`ifdef D16_FETCH_PREFETCH_EN
  logic [1:0]  cnt;
  logic [55:0] fifo_dat [2];
  logic [15:0] fifo_pc  [2];
  logic        pop, push, push_slot;

  // An entry leaves whenever the stage accepts; a returning word is queued
  // unless it can bypass straight into LI/DI (FIFO empty and stage enabled).
  assign pop       = (state == REQ) && en && (cnt != 2'd0);
  assign imem_stb  = (state == REQ) && ((cnt != 2'd2) || pop);
  assign push      = ack_ok && !(en && (cnt == 2'd0));
  assign push_slot = ((cnt == 2'd2) || ((cnt == 2'd1) && !pop));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      default: state_nxt = REQ;
    endcase
    if (jmp) state_nxt = REQ;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pc       <= 16'd0;
      cnt      <= 2'd0;
      li_di_op <= 8'd0;
      li_di_a  <= 16'd0;
      li_di_b  <= 16'd0;
      li_di_c  <= 16'd0;
      li_pc    <= 16'd0;
    end else if (jmp) begin
      pc       <= jmp_addr;
      cnt      <= 2'd0;
      li_di_op <= 8'd0;
    end else if (state == REQ) begin
      if (ack_ok) pc <= pc + 16'd1;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        {li_di_op, li_di_a, li_di_b, li_di_c} <= fifo_dat[0];
        li_pc <= fifo_pc[0];
      end else if (en) begin
        if (ack_ok) begin
          {li_di_op, li_di_a, li_di_b, li_di_c} <= imem_dat;
          li_pc <= pc;
        end else begin
          li_di_op <= 8'd0;
        end
      end
    end
  end

  // FIFO storage; validity lives entirely in cnt. The shift happens first so
  // a push into slot 0 during a pop overrides it.
  always_ff @(posedge sys_clk) begin
    if (pop) begin
      fifo_dat[0] <= fifo_dat[1];
      fifo_pc[0]  <= fifo_pc[1];
    end
    if (push) begin
      if (push_slot) begin
        fifo_dat[1] <= imem_dat;
        fifo_pc[1]  <= pc;
      end else begin
        fifo_dat[0] <= imem_dat;
        fifo_pc[0]  <= pc;
      end
    end
  end
`else
  logic [55:0] hold_dat;
  logic [15:0] hold_pc;

  assign imem_stb = (state == REQ);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (ack_ok && !en) state_nxt = HOLD;
      HOLD:    if (en) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (jmp) state_nxt = REQ;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pc       <= 16'd0;
      li_di_op <= 8'd0;
      li_di_a  <= 16'd0;
      li_di_b  <= 16'd0;
      li_di_c  <= 16'd0;
      li_pc    <= 16'd0;
    end else if (jmp) begin
      pc       <= jmp_addr;
      li_di_op <= 8'd0;
    end else begin
      case (state)
        REQ: begin
          if (ack_ok) begin
            pc <= pc + 16'd1;
            if (en) begin
              {li_di_op, li_di_a, li_di_b, li_di_c} <= imem_dat;
              li_pc <= pc;
            end
          end else if (en) begin
            li_di_op <= 8'd0;
          end
        end
        HOLD: begin
          if (en) begin
            {li_di_op, li_di_a, li_di_b, li_di_c} <= hold_dat;
            li_pc <= hold_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Hold register contents are only meaningful while in HOLD.
  always_ff @(posedge sys_clk) begin
    if (state == REQ && ack_ok && !en) begin
      hold_dat <= imem_dat;
      hold_pc  <= pc;
    end
  end
`endif

endmodule

// File: tb/tb_d16_fetch.sv
module tb_d16_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst, en, jmp, imem_ack, imem_stb;
  logic [15:0] jmp_addr, imem_adr;
  logic [55:0] imem_dat;
  logic [7:0]  li_di_op;
  logic [15:0] li_di_a, li_di_b, li_di_c, li_pc;

  always #5 sys_clk = ~sys_clk;

  d16_fetch dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .jmp      (jmp),
    .jmp_addr (jmp_addr),
    .imem_adr (imem_adr),
    .imem_stb (imem_stb),
    .imem_ack (imem_ack),
    .imem_dat (imem_dat),
    .li_di_op (li_di_op),
    .li_di_a  (li_di_a),
    .li_di_b  (li_di_b),
    .li_di_c  (li_di_c),
    .li_pc    (li_pc)
  );

  typedef struct {
    logic        e;
    logic        j;
    logic [15:0] ja;
    logic        a;
    int          xstb;
    logic [15:0] xadr;
    int          xop;
    int          xpc;
    bit          cabc;
  } vec_t;

  vec_t        vec[$];
  logic [71:0] sb[$];
  int          ntot = 0;
  int          nbad = 0;
  logic [7:0]  prev_op = 8'd0;
  logic [15:0] prev_pc = 16'd0;

  // Memory image: every word is a distinct function of its address, op has
  // bit 7 set so it never looks like a bubble.
  function automatic logic [55:0] mk(input logic [15:0] ad);
    logic [7:0] op;
    op = {1'b1, ad[6:0] ^ ad[13:7]};
    return {op, ad ^ 16'h1234, ~ad, ad + 16'h0101};
  endfunction

  function automatic int op_of(input logic [15:0] ad);
    logic [55:0] w;
    w = mk(ad);
    return int'(w[55:48]);
  endfunction

  function automatic void add(input logic e, input logic j, input logic [15:0] ja,
                              input logic a, input int xstb, input logic [15:0] xadr,
                              input int xop, input int xpc, input bit cabc);
    vec_t v;
    v.e = e; v.j = j; v.ja = ja; v.a = a; v.xstb = xstb; v.xadr = xadr;
    v.xop = xop; v.xpc = xpc; v.cabc = cabc;
    vec.push_back(v);
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Any newly loaded instruction must be the oldest one still owed.
  task automatic monitor();
    logic [71:0] cur;
    cur = {li_di_op, li_di_a, li_di_b, li_di_c, li_pc};
    if (li_di_op != 8'd0 && (li_di_op != prev_op || li_pc != prev_pc)) begin
      if (sb.size() == 0) begin
        ntot++;
        nbad++;
        $display("FAIL sb_extra: got %0h want none", cur);
      end else begin
        check("sb_instr", cur, sb.pop_front());
      end
    end
    prev_op = li_di_op;
    prev_pc = li_pc;
  endtask

  task automatic step(input logic r, input logic e, input logic j, input logic [15:0] ja,
                      input logic a, input int xstb, input logic [15:0] xadr,
                      input int xop, input int xpc, input bit cabc);
    logic [55:0] w;
    @(negedge sys_clk);
    sys_rst = r; en = e; jmp = j; jmp_addr = ja; imem_ack = 1'b0;
    #1;
    if (xstb >= 0) begin
      check("stb", 72'(imem_stb), 72'(xstb));
      if (xstb == 1) check("adr", 72'(imem_adr), 72'(xadr));
    end
    imem_dat = mk(imem_adr);
    imem_ack = a;
    if (j || r) sb.delete();
    else if (a && imem_stb) sb.push_back({mk(imem_adr), imem_adr});
    @(posedge sys_clk);
    #1;
    monitor();
    if (xop >= 0) check("op", 72'(li_di_op), 72'(xop));
    if (xpc >= 0) check("li_pc", 72'(li_pc), 72'(xpc));
    if (cabc) begin
      w = mk(16'(xpc));
      check("abc", 72'({li_di_a, li_di_b, li_di_c}), 72'(w[47:0]));
    end
  endtask

  task automatic check_reset_state();
    check("rst_op", 72'(li_di_op), 72'd0);
    check("rst_abc", 72'({li_di_a, li_di_b, li_di_c}), 72'd0);
    check("rst_pc", 72'(li_pc), 72'd0);
    check("rst_stb", 72'(imem_stb), 72'd0);
    check("rst_adr", 72'(imem_adr), 72'd0);
  endtask

  initial begin
    sys_rst = 1'b1; en = 1'b0; jmp = 1'b0; jmp_addr = 16'd0;
    imem_ack = 1'b0; imem_dat = 56'd0;

    // Streaming, jump over an ack, ack latency, wrap at 0xFFFF.
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    for (int k = 0; k < 7; k++) add(1, 0, 16'h0000, 1, 1, 16'(k), op_of(16'(k)), k, 1);
    add(1, 1, 16'h0100, 1, 1, 16'h0007, 0, 6, 1);
    add(1, 0, 16'h0000, 1, 1, 16'h0100, op_of(16'h0100), 16'h0100, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 16'h0000, 0, 1, 16'h0101, 0, 16'h0100, 1);
    add(1, 0, 16'h0000, 1, 1, 16'h0101, op_of(16'h0101), 16'h0101, 1);
    add(1, 1, 16'hFFFE, 0, 1, 16'h0102, 0, 16'h0101, 1);
    add(1, 0, 16'h0000, 1, 1, 16'hFFFE, op_of(16'hFFFE), 16'hFFFE, 1);
    add(1, 0, 16'h0000, 1, 1, 16'hFFFF, op_of(16'hFFFF), 16'hFFFF, 1);
    add(1, 0, 16'h0000, 1, 1, 16'h0000, op_of(16'h0000), 16'h0000, 1);

    step(1, 0, 0, 16'h0000, 0, -1, 16'h0000, -1, -1, 0);
    step(1, 0, 0, 16'h0000, 1, -1, 16'h0000, -1, -1, 0);
    check_reset_state();

    foreach (vec[i])
      step(0, vec[i].e, vec[i].j, vec[i].ja, vec[i].a, vec[i].xstb, vec[i].xadr,
           vec[i].xop, vec[i].xpc, vec[i].cabc);

    // Reset pulse in the middle of an unanswered request.
    step(0, 1, 0, 16'h0000, 0, 1, 16'h0001, 0, 0, 1);
    step(0, 1, 0, 16'h0000, 0, 1, 16'h0001, 0, 0, 1);
    step(1, 1, 0, 16'h0000, 1, -1, 16'h0000, -1, -1, 0);
    check_reset_state();
    step(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 16'h0000, 1, 1, 16'(k), op_of(16'(k)), k, 1);

    // Stall while instruction 5 returns; 5 and 6 must emerge in order.
`ifdef D16_FETCH_PREFETCH_EN
    step(0, 0, 0, 16'h0000, 1, 1, 16'h0005, op_of(16'h0004), 4, 1);
    step(0, 0, 0, 16'h0000, 1, 1, 16'h0006, op_of(16'h0004), 4, 1);
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000, op_of(16'h0004), 4, 1);
    step(0, 1, 0, 16'h0000, 0, 1, 16'h0007, op_of(16'h0005), 5, 1);
    step(0, 1, 0, 16'h0000, 0, 1, 16'h0007, op_of(16'h0006), 6, 1);
    step(0, 1, 0, 16'h0000, 1, 1, 16'h0007, op_of(16'h0007), 7, 1);
`else
    step(0, 0, 0, 16'h0000, 1, 1, 16'h0005, op_of(16'h0004), 4, 1);
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000, op_of(16'h0004), 4, 1);
    step(0, 0, 0, 16'h0000, 0, 0, 16'h0000, op_of(16'h0004), 4, 1);
    step(0, 1, 0, 16'h0000, 0, 0, 16'h0000, op_of(16'h0005), 5, 1);
    step(0, 1, 0, 16'h0000, 1, 1, 16'h0006, op_of(16'h0006), 6, 1);
    step(0, 1, 0, 16'h0000, 1, 1, 16'h0007, op_of(16'h0007), 7, 1);
`endif

    // Jump while stalled still flushes and redirects.
    step(0, 0, 1, 16'h0200, 1, 1, 16'h0008, 0, 7, 1);
    step(0, 1, 0, 16'h0000, 1, 1, 16'h0200, op_of(16'h0200), 16'h0200, 1);

    check("sb_drained", 72'(sb.size()), 72'd0);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
